ssp_tx_logic: RTL and testbench
===============================

Name: ssp_tx_logic

Overview:
Transmit serializer for the SSP, directly downstream of the transmit FIFO.
- Pops bytes from the FIFO via LOGICWRITE and frames each with a one-period SSPFSSOUT pulse.
- Shifts each byte out MSB-first on SSPTXD, synchronous to a generated SSPCLKOUT.
- Runs words back-to-back with no idle gap while the FIFO stays non-empty.

Parameters:
DATA_W, 8, word width. Must match the FIFO width.
CLK_DIV, 2, PCLK cycles per SSPCLKOUT period. Even, >= 2.

Ports:
PCLK  input  1  system clock; all logic on posedge
CLEAR_B  input  1  synchronous active-low clear
TxDATA  input  DATA_W  FIFO head word, valid whenever EMPTY=0
EMPTY  input  1  FIFO empty flag
LOGICWRITE  output  1  one-PCLK pop strobe to the FIFO
SSPCLKOUT  output  1  serial clock, free-running
SSPFSSOUT  output  1  frame sync, high for one SSPCLKOUT period before each MSB
SSPTXD  output  1  serial data
SSPOE_B  output  1  active-low pad output enable
TX_BUSY  output  1  high when the FSM is not IDLE

Behaviour:
- Clock and reset: one clock, PCLK. Reset CLEAR_B is synchronous and active-low.
- Reset values: SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, TX_BUSY=0, LOGICWRITE=0, divider=0, state=IDLE.
- Reset mid-word: discards the in-flight word (not returned to the FIFO). Reset has priority over everything.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - At div_cnt==CLK_DIV/2-1 the edge drives SSPCLKOUT<=0.
  - At div_cnt==CLK_DIV-1 the edge drives SSPCLKOUT<=1. This PCLK cycle is the rise tick.
  - With CLK_DIV=2, SSPCLKOUT toggles every PCLK cycle.
- Update timing: all SSPTXD/SSPFSSOUT/SSPOE_B/state updates occur only at rise-tick edges, so the receiver samples on the SSPCLKOUT falling edge.
- LOGICWRITE:
  - Combinational: asserted exactly in a rise-tick cycle where a load occurs.
  - The FIFO pops at the same edge that captures TxDATA into shift_reg.
  - Never asserted when EMPTY=1.
- IDLE: at a rise tick with EMPTY=0:
  - Load shift_reg<=TxDATA and pulse LOGICWRITE.
  - SSPFSSOUT<=1, SSPOE_B<=0.
  - Go to FRAME.
  - If EMPTY=1: stay, SSPTXD=0, SSPOE_B=1.
- FRAME: next rise tick.
  - SSPFSSOUT<=0, SSPTXD<=shift_reg[DATA_W-1], shift_reg<<=1, bit_cnt<=DATA_W-1.
  - Go to SHIFT.
- SHIFT, bit_cnt>1: each rise tick drives the next bit and decrements bit_cnt.
- SHIFT, bit_cnt==1: this edge drives the LSB and sets bit_cnt<=0.
  - If EMPTY=0 at this edge: load the next word into shift_reg, pulse LOGICWRITE, SSPFSSOUT<=1. The frame pulse overlaps the LSB period.
- SHIFT, bit_cnt==0 (LSB period ending), at the next rise tick:
  - If a word was preloaded: SSPFSSOUT<=0, drive its MSB, bit_cnt<=DATA_W-1, stay in SHIFT.
  - Else: SSPTXD<=0, SSPOE_B<=1, go to IDLE.
  - A word arriving during the LSB period without preload goes through IDLE/FRAME.
- Frame length: one isolated word occupies SSPOE_B low for DATA_W+1 SSPCLKOUT periods. N back-to-back words occupy N*DATA_W+1 periods.
- TX_BUSY = (state != IDLE).
- Width rule: bit_cnt is clog2(DATA_W)+1 bits. The FIFO never sees LOGICWRITE with EMPTY=1.

Optional Feature:
SSP_TX_LSB_FIRST_EN
- Defined: bits leave LSB-first (SSPTXD takes shift_reg[0], shift right). Framing and timing are unchanged.
- Undefined: MSB-first as above.

Test Plan:
- Reset: hold CLEAR_B=0 for 3 cycles mid-word (bit 4 of 0xA5), then release -> next edge SSPOE_B=1, SSPFSSOUT=0, SSPTXD=0, TX_BUSY=0, no LOGICWRITE until EMPTY=0.
- Single word, CLK_DIV=2: FIFO holds 0xA5 -> one LOGICWRITE at the first rise tick; SSPFSSOUT high 1 period; SSPTXD 1,0,1,0,0,1,0,1 on successive rise ticks; SSPOE_B low 18 PCLK cycles; then IDLE.
- Back-to-back: FIFO holds 0x3C and 0xC3 -> second LOGICWRITE at the LSB-drive edge of 0x3C; SSPFSSOUT high during that LSB period; 0xC3 MSB follows with no gap; SSPOE_B low 17 SSPCLKOUT periods total.
- Empty boundary: FIFO becomes non-empty one PCLK after the LSB-drive edge -> no preload; return to IDLE (SSPOE_B=1 one period); new frame starts at the following rise tick.
- Divider: CLK_DIV=4 with 0xFF -> SSPCLKOUT period 4 PCLK, 50% duty; data changes only on rising edges; 9 periods = 36 PCLK with SSPOE_B low.
- SSP_TX_LSB_FIRST_EN defined with 0x01 -> SSPTXD 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/ssp_tx_logic.sv
// ssp_tx_logic: SSP transmit serializer between the TX FIFO and the pads.
// Define SSP_TX_LSB_FIRST_EN to send words LSB-first; the default is MSB-first.
module ssp_tx_logic #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic [DATA_W-1:0] TxDATA,
    input  logic              EMPTY,
    output logic              LOGICWRITE,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    output logic              TX_BUSY
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              sclk_q, sclk_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              fss_q, fss_d;
    logic              txd_q, txd_d;
    logic              oe_b_q, oe_b_d;
    logic              preload_q, preload_d;

    logic              rise_tick;
    logic              load;
    logic              out_bit;
    logic [DATA_W-1:0] shifted;

`ifdef SSP_TX_LSB_FIRST_EN
    assign out_bit = shift_q[0];
    assign shifted = shift_q >> 1;
`else
    assign out_bit = shift_q[DATA_W-1];
    assign shifted = shift_q << 1;
`endif

    assign rise_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        div_cnt_d = rise_tick ? '0 : div_cnt_q + DIV_W'(1);
        sclk_d    = sclk_q;
        if (div_cnt_q == DIV_HALF) begin
            sclk_d = 1'b0;
        end else if (rise_tick) begin
            sclk_d = 1'b1;
        end
    end

    // Framing only advances on rise ticks, so data is stable around the falling edge.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        fss_d     = fss_q;
        txd_d     = txd_q;
        oe_b_d    = oe_b_q;
        preload_d = preload_q;
        load      = 1'b0;

        if (rise_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!EMPTY) begin
                        load    = 1'b1;
                        fss_d   = 1'b1;
                        oe_b_d  = 1'b0;
                        state_d = ST_FRAME;
                    end else begin
                        txd_d  = 1'b0;
                        oe_b_d = 1'b1;
                    end
                end
                ST_FRAME: begin
                    fss_d     = 1'b0;
                    txd_d     = out_bit;
                    shift_d   = shifted;
                    bit_cnt_d = CNT_TOP;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt_q > CNT_ONE) begin
                        txd_d     = out_bit;
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q - CNT_ONE;
                    end else if (bit_cnt_q == CNT_ONE) begin
                        // Last bit goes out; a waiting word is fetched now so it follows gap-free.
                        txd_d     = out_bit;
                        shift_d   = shifted;
                        bit_cnt_d = '0;
                        preload_d = !EMPTY;
                        if (!EMPTY) begin
                            load  = 1'b1;
                            fss_d = 1'b1;
                        end
                    end else if (preload_q) begin
                        fss_d     = 1'b0;
                        txd_d     = out_bit;
                        shift_d   = shifted;
                        bit_cnt_d = CNT_TOP;
                        preload_d = 1'b0;
                    end else begin
                        txd_d   = 1'b0;
                        oe_b_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    txd_d   = 1'b0;
                    oe_b_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (load) begin
            shift_d = TxDATA;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            fss_q     <= 1'b0;
            txd_q     <= 1'b0;
            oe_b_q    <= 1'b1;
            preload_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            fss_q     <= fss_d;
            txd_q     <= txd_d;
            oe_b_q    <= oe_b_d;
            preload_q <= preload_d;
        end
    end

    // The pop strobe is masked by clear so an in-flight word is never popped during reset.
    assign LOGICWRITE = load && CLEAR_B;
    assign SSPCLKOUT  = sclk_q;
    assign SSPFSSOUT  = fss_q;
    assign SSPTXD     = txd_q;
    assign SSPOE_B    = oe_b_q;
    assign TX_BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ssp_tx_logic.sv
// Bench for ssp_tx_logic: a period-queue model of the serial line checked every PCLK,
// plus directed scenarios with hand-computed literal results (second instance for CLK_DIV=4).
module tb_ssp_tx_logic;

    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 2;

    typedef struct packed {
        logic fss;
        logic txd;
        logic oe_b;
    } per_t;

    logic             PCLK;
    logic             CLEAR_B;
    logic [DATA_W-1:0] TxDATA;
    logic             EMPTY;
    logic             LOGICWRITE, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, TX_BUSY;

    logic [DATA_W-1:0] TxDATA4;
    logic             EMPTY4;
    logic             LOGICWRITE4, SSPCLKOUT4, SSPFSSOUT4, SSPTXD4, SSPOE_B4, TX_BUSY4;

    ssp_tx_logic #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .TxDATA    (TxDATA),
        .EMPTY     (EMPTY),
        .LOGICWRITE(LOGICWRITE),
        .SSPCLKOUT (SSPCLKOUT),
        .SSPFSSOUT (SSPFSSOUT),
        .SSPTXD    (SSPTXD),
        .SSPOE_B   (SSPOE_B),
        .TX_BUSY   (TX_BUSY)
    );

    ssp_tx_logic #(.DATA_W(DATA_W), .CLK_DIV(4)) u_dut4 (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .TxDATA    (TxDATA4),
        .EMPTY     (EMPTY4),
        .LOGICWRITE(LOGICWRITE4),
        .SSPCLKOUT (SSPCLKOUT4),
        .SSPFSSOUT (SSPFSSOUT4),
        .SSPTXD    (SSPTXD4),
        .SSPOE_B   (SSPOE_B4),
        .TX_BUSY   (TX_BUSY4)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int total;
    int bad;

    // Model: future serial-line periods, the period currently on the line, edges since reset.
    logic [DATA_W-1:0] fifo_q[$];
    per_t plan[$];
    per_t cur;
    int   k;
    bit   valid;
    bit   pop_req;

    int          oe_low, lw_cnt, fss_cyc, nbits, gap, pend_high;
    logic [31:0] bits;
    bit          seen_low, prev_clk, last_rise_oe;

    bit en4, pop4, have_edge4, prev_clk4, prev_txd4, prev_oe4;
    int lw4_cnt, oe4_low, ones4, runs4, bad_runs4, run_len4, viol4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        for (int i = 0; i < DATA_W; i++) begin
`ifdef SSP_TX_LSB_FIRST_EN
            plan.push_back('{1'b0, w[i], 1'b0});
`else
            plan.push_back('{1'b0, w[DATA_W-1-i], 1'b0});
`endif
        end
    endtask

    function automatic logic exp_clk(input int edges);
        return (edges >= CLK_DIV) && ((edges % CLK_DIV) < CLK_DIV / 2);
    endfunction

    task automatic model_step();
        per_t nxt;
        bit   lw_exp;
        int   nk;
        lw_exp = 1'b0;
        nxt    = cur;
        if (!CLEAR_B) begin
            nk  = 0;
            nxt = '{1'b0, 1'b0, 1'b1};
            plan.delete();
        end else begin
            nk = k + 1;
            if ((k % CLK_DIV) == CLK_DIV - 1) begin
                if (plan.size() > 0) begin
                    nxt = plan.pop_front();
                    if (plan.size() == 0 && !EMPTY) begin
                        nxt.fss = 1'b1;
                        lw_exp  = 1'b1;
                        push_word(TxDATA);
                    end
                end else if (cur.oe_b && !EMPTY) begin
                    nxt    = '{1'b1, 1'b0, 1'b0};
                    lw_exp = 1'b1;
                    push_word(TxDATA);
                end else begin
                    nxt = '{1'b0, 1'b0, 1'b1};
                end
            end
        end
        if (valid) begin
            check("sspclkout", SSPCLKOUT, exp_clk(k));
            check("sspfssout", SSPFSSOUT, cur.fss);
            check("ssptxd", SSPTXD, cur.txd);
            check("sspoe_b", SSPOE_B, cur.oe_b);
            check("tx_busy", TX_BUSY, !cur.oe_b);
            check("logicwrite", LOGICWRITE, lw_exp);
        end
        if (LOGICWRITE) lw_cnt++;
        if (LOGICWRITE4) begin
            pop4 = 1'b1;
            if (en4) lw4_cnt++;
        end
        pop_req = lw_exp;
        cur     = nxt;
        k       = nk;
        valid   = 1'b1;
    endtask

    task automatic drive_fifo();
        EMPTY  = (fifo_q.size() == 0);
        TxDATA = EMPTY ? '0 : fifo_q[0];
    endtask

    task automatic sample();
        bit rise, rise4;
        rise = SSPCLKOUT && !prev_clk;
        if (!SSPOE_B) oe_low++;
        if (SSPFSSOUT) fss_cyc++;
        if (!SSPOE_B) begin
            if (seen_low && pend_high > 0) gap = pend_high;
            pend_high = 0;
            seen_low  = 1'b1;
        end else if (seen_low) begin
            pend_high++;
        end
        if (rise) begin
            if (!SSPOE_B && !last_rise_oe) begin
                bits = {bits[30:0], SSPTXD};
                nbits++;
            end
            last_rise_oe = SSPOE_B;
        end
        prev_clk = SSPCLKOUT;

        if (en4) begin
            rise4 = SSPCLKOUT4 && !prev_clk4;
            if (!SSPOE_B4) oe4_low++;
            if (SSPTXD4) ones4++;
            if ((SSPTXD4 != prev_txd4 || SSPOE_B4 != prev_oe4) && !rise4) viol4++;
            if (SSPCLKOUT4 != prev_clk4) begin
                if (have_edge4) begin
                    runs4++;
                    if (run_len4 != 2) bad_runs4++;
                end
                have_edge4 = 1'b1;
                run_len4   = 1;
            end else begin
                run_len4++;
            end
            prev_clk4 = SSPCLKOUT4;
            prev_txd4 = SSPTXD4;
            prev_oe4  = SSPOE_B4;
        end
    endtask

    task automatic cycle();
        @(negedge PCLK);
        model_step();
        @(posedge PCLK);
        #1;
        if (pop_req) begin
            if (fifo_q.size() > 0) fifo_q.delete(0);
            pop_req = 1'b0;
        end
        if (pop4) begin
            EMPTY4 = 1'b1;
            pop4   = 1'b0;
        end
        drive_fifo();
        #1;
        sample();
    endtask

    task automatic reset_cap();
        oe_low       = 0;
        lw_cnt       = 0;
        fss_cyc      = 0;
        nbits        = 0;
        gap          = 0;
        pend_high    = 0;
        bits         = '0;
        seen_low     = 1'b0;
        last_rise_oe = 1'b1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    initial begin
        bit found;
        total   = 0;
        bad     = 0;
        k       = 0;
        valid   = 1'b0;
        cur     = '{1'b0, 1'b0, 1'b1};
        pop_req = 1'b0;
        pop4    = 1'b0;
        en4     = 1'b0;
        prev_clk = 1'b0;
        CLEAR_B = 1'b0;
        EMPTY   = 1'b1;
        TxDATA  = '0;
        EMPTY4  = 1'b1;
        TxDATA4 = 8'hFF;
        reset_cap();

        repeat (3) cycle();
        CLEAR_B = 1'b1;
        repeat (4) cycle();
        check("rst_oe_b", SSPOE_B, 1'b1);
        check("rst_busy", TX_BUSY, 1'b0);
        check("rst_txd", SSPTXD, 1'b0);

        // Single word 0xA5
        reset_cap();
        push(8'hA5);
        repeat (30) cycle();
        check("t1_bits", bits, 32'hA5);
        check("t1_nbits", nbits, 8);
        check("t1_oe_low", oe_low, 18);
        check("t1_lw_cnt", lw_cnt, 1);
        check("t1_fss_cyc", fss_cyc, 2);

        // Back-to-back 0x3C, 0xC3
        reset_cap();
        push(8'h3C);
        push(8'hC3);
        repeat (50) cycle();
        check("t2_bits", bits, 32'h3CC3);
        check("t2_nbits", nbits, 16);
        check("t2_oe_low", oe_low, 34);
        check("t2_lw_cnt", lw_cnt, 2);
        check("t2_fss_cyc", fss_cyc, 4);
        check("t2_gap", gap, 0);

        // Word arrives one PCLK after the LSB-drive edge: no preload
        push(8'h5A);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (plan.size() == 0 && !cur.oe_b) found = 1'b1;
        end
        check("t3_wait_lsb", found, 1'b1);
        push(8'h81);
        reset_cap();
        repeat (40) cycle();
        check("t3_gap", gap, 2);
        check("t3_lw_cnt", lw_cnt, 1);
        check("t3_bits", bits, 32'h81);

        // Reset while bit 4 of 0xA5 is on the line
        push(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (plan.size() == 4 && !cur.oe_b) found = 1'b1;
        end
        check("t4_wait_bit4", found, 1'b1);
        check("t4_bit4_txd", SSPTXD, 1'b0);
        check("t4_busy_mid", TX_BUSY, 1'b1);
        CLEAR_B = 1'b0;
        repeat (3) cycle();
        CLEAR_B = 1'b1;
        cycle();
        check("t4_oe_b", SSPOE_B, 1'b1);
        check("t4_fss", SSPFSSOUT, 1'b0);
        check("t4_txd", SSPTXD, 1'b0);
        check("t4_busy", TX_BUSY, 1'b0);
        check("t4_lw", LOGICWRITE, 1'b0);
        reset_cap();
        repeat (10) cycle();
        check("t4_lw_cnt", lw_cnt, 0);
        check("t4_oe_low", oe_low, 0);

        // Bit order with 0x01
        reset_cap();
        push(8'h01);
        repeat (30) cycle();
`ifdef SSP_TX_LSB_FIRST_EN
        check("t5_bits", bits, 32'h80);
`else
        check("t5_bits", bits, 32'h01);
`endif
        check("t5_nbits", nbits, 8);

        // CLK_DIV=4 instance sending 0xFF
        lw4_cnt    = 0;
        oe4_low    = 0;
        ones4      = 0;
        runs4      = 0;
        bad_runs4  = 0;
        run_len4   = 0;
        viol4      = 0;
        have_edge4 = 1'b0;
        prev_clk4  = SSPCLKOUT4;
        prev_txd4  = SSPTXD4;
        prev_oe4   = SSPOE_B4;
        en4        = 1'b1;
        EMPTY4     = 1'b0;
        repeat (60) cycle();
        en4 = 1'b0;
        check("t6_lw_cnt", lw4_cnt, 1);
        check("t6_oe_low", oe4_low, 36);
        check("t6_ones", ones4, 32);
        check("t6_bad_runs", bad_runs4, 0);
        check("t6_runs_seen", runs4 > 20, 1'b1);
        check("t6_off_edge_change", viol4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
